// File: rtl/vending_machine_param.sv
// Vending machine: coin or card payment against per-slot price/stock tables, greedy change from saturating tubes.
// All outputs registered; coins are credited the cycle after their strobe, and change is paid out one coin per cycle.
module vending_machine_param #(
    parameter int  N_PROD    = 8,
    parameter int  PRICE_W   = 9,
    parameter int  INV_W     = 3,
    parameter int  TUBE_W    = 5,
    parameter int  TUBE_INIT = 10,
    parameter int  TIMEOUT   = 16,
    localparam int IDX_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [N_PROD*PRICE_W-1:0] cost_in,
    input  logic [N_PROD*INV_W-1:0]   inv_in,
    input  logic [IDX_W-1:0]          index,
    input  logic                      pay_card,
    input  logic [PRICE_W-1:0]        card_balance,
    input  logic                      nickel,
    input  logic                      dime,
    input  logic                      quarter,
    input  logic                      dollar,
    input  logic                      cancel,
    output logic                      dispensed,
    output logic                      sold_out,
    output logic                      coin_reject,
    output logic [PRICE_W-1:0]        credit,
    output logic [PRICE_W-1:0]        owed,
    output logic [TUBE_W-1:0]         quart,
    output logic [TUBE_W-1:0]         dim,
    output logic [TUBE_W-1:0]         nick,
    output logic                      change_done,
    output logic                      exact_change,
    output logic [N_PROD*INV_W-1:0]   inv_out
);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int SUM_W = PRICE_W + 8;

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t                         state_q, state_d;
    logic [N_PROD-1:0][PRICE_W-1:0] price_q, price_d;
    logic [N_PROD-1:0][INV_W-1:0]   inv_q, inv_d;
    logic [PRICE_W-1:0]             credit_q, credit_d, owed_q, owed_d;
    logic [TUBE_W-1:0]              tq_q, tq_d, td_q, td_d, tn_q, tn_d;
    logic [TUBE_W-1:0]              quart_q, quart_d, dim_q, dim_d, nick_q, nick_d;
    logic [TO_W-1:0]                to_q, to_d;
    logic [IDX_W-1:0]               vidx_q, vidx_d;
    logic                           vcard_q, vcard_d;
    logic                           disp_q, disp_d, sold_q, sold_d, rej_q, rej_d;
    logic                           done_q, done_d, exact_q, exact_d;

    logic               coin_any, coin_phase, coin_ovf, coin_ok;
    logic [SUM_W-1:0]   credit_ext;
    logic [PRICE_W-1:0] cur_price, vend_price;
    logic [INV_W-1:0]   cur_inv;
    logic               card_go, coin_go, timeout_hit, give_q, give_d, give_n;

    assign coin_any   = nickel | dime | quarter | dollar;
    assign coin_phase = (state_q == IDLE) || (state_q == COLLECT);
    assign credit_ext = SUM_W'(credit_q)
                      + (nickel  ? SUM_W'(5)   : '0)
                      + (dime    ? SUM_W'(10)  : '0)
                      + (quarter ? SUM_W'(25)  : '0)
                      + (dollar  ? SUM_W'(100) : '0);
    assign coin_ovf   = credit_ext > SUM_W'((2 ** PRICE_W) - 1);
    assign coin_ok    = coin_phase && coin_any && !coin_ovf;

    assign cur_price   = price_q[index];
    assign cur_inv     = inv_q[index];
    assign vend_price  = price_q[vidx_q];
    assign card_go     = pay_card && (card_balance >= cur_price) && (cur_inv != '0);
    assign coin_go     = (credit_q >= cur_price) && (cur_inv != '0);
    assign timeout_hit = !coin_any && (to_q == TO_W'(TIMEOUT - 1));
    assign give_q      = (credit_q >= PRICE_W'(25)) && (tq_q != '0);
    assign give_d      = (credit_q >= PRICE_W'(10)) && (td_q != '0);
    assign give_n      = (credit_q >= PRICE_W'(5))  && (tn_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            price_q  <= '0;
            inv_q    <= '0;
            credit_q <= '0;
            owed_q   <= '0;
            tq_q     <= TUBE_W'(TUBE_INIT);
            td_q     <= TUBE_W'(TUBE_INIT);
            tn_q     <= TUBE_W'(TUBE_INIT);
            quart_q  <= '0;
            dim_q    <= '0;
            nick_q   <= '0;
            to_q     <= '0;
            vidx_q   <= '0;
            vcard_q  <= 1'b0;
            disp_q   <= 1'b0;
            sold_q   <= 1'b0;
            rej_q    <= 1'b0;
            done_q   <= 1'b0;
            exact_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            price_q  <= price_d;
            inv_q    <= inv_d;
            credit_q <= credit_d;
            owed_q   <= owed_d;
            tq_q     <= tq_d;
            td_q     <= td_d;
            tn_q     <= tn_d;
            quart_q  <= quart_d;
            dim_q    <= dim_d;
            nick_q   <= nick_d;
            to_q     <= to_d;
            vidx_q   <= vidx_d;
            vcard_q  <= vcard_d;
            disp_q   <= disp_d;
            sold_q   <= sold_d;
            rej_q    <= rej_d;
            done_q   <= done_d;
            exact_q  <= exact_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (coin_ok)      state_d = COLLECT;
                else if (card_go) state_d = VEND;
            end
            COLLECT: begin
                if (cancel || timeout_hit) state_d = CHANGE;
                else if (coin_go)          state_d = VEND;
            end
            VEND:    state_d = (!vcard_q && (credit_q != vend_price)) ? CHANGE : IDLE;
            CHANGE:  if (!(give_q || give_d || give_n)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        price_d  = price_q;
        inv_d    = inv_q;
        credit_d = credit_q;
        owed_d   = owed_q;
        tq_d     = tq_q;
        td_d     = td_q;
        tn_d     = tn_q;
        quart_d  = quart_q;
        dim_d    = dim_q;
        nick_d   = nick_q;
        to_d     = '0;
        vidx_d   = vidx_q;
        vcard_d  = vcard_q;
        disp_d   = 1'b0;
        sold_d   = 1'b0;
        rej_d    = 1'b0;
        done_d   = 1'b0;

        // Slot and payment mode track the inputs until the vend actually happens.
        if (coin_phase) begin
            vidx_d  = index;
            vcard_d = (state_q == IDLE);
        end

        if (coin_phase && coin_any) begin
            if (coin_ovf) begin
                rej_d = 1'b1;
            end else begin
                credit_d = credit_ext[PRICE_W-1:0];
                if (nickel  && (tn_q != '1)) tn_d = tn_q + TUBE_W'(1);
                if (dime    && (td_q != '1)) td_d = td_q + TUBE_W'(1);
                if (quarter && (tq_q != '1)) tq_d = tq_q + TUBE_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (load) begin
                    price_d = cost_in;
                    inv_d   = inv_in;
                end
                if (coin_ok) begin
                    quart_d = '0;
                    dim_d   = '0;
                    nick_d  = '0;
                end
            end
            COLLECT: begin
                sold_d = (cur_inv == '0);
                if ((state_d == COLLECT) && !coin_any) to_d = to_q + TO_W'(1);
            end
            VEND: begin
                disp_d        = 1'b1;
                inv_d[vidx_q] = inv_q[vidx_q] - INV_W'(1);
                if (!vcard_q) credit_d = credit_q - vend_price;
            end
            CHANGE: begin
                if (give_q) begin
                    tq_d     = tq_q - TUBE_W'(1);
                    quart_d  = quart_q + TUBE_W'(1);
                    credit_d = credit_q - PRICE_W'(25);
                end else if (give_d) begin
                    td_d     = td_q - TUBE_W'(1);
                    dim_d    = dim_q + TUBE_W'(1);
                    credit_d = credit_q - PRICE_W'(10);
                end else if (give_n) begin
                    tn_d     = tn_q - TUBE_W'(1);
                    nick_d   = nick_q + TUBE_W'(1);
                    credit_d = credit_q - PRICE_W'(5);
                end else begin
                    owed_d   = credit_q;
                    credit_d = '0;
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase

        exact_d = (tn_d == '0) || (td_d == '0);
    end

    assign dispensed    = disp_q;
    assign sold_out     = sold_q;
    assign coin_reject  = rej_q;
    assign credit       = credit_q;
    assign owed         = owed_q;
    assign quart        = quart_q;
    assign dim          = dim_q;
    assign nick         = nick_q;
    assign change_done  = done_q;
    assign exact_change = exact_q;
    assign inv_out      = inv_q;
endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param at default parameters: a cycle-accurate vector table
// followed by hand-written multi-cycle scenarios (card vend, tube drain, timeout, reset mid-change).
module tb_vending_machine_param;
    logic        clk = 1'b0;
    logic        rst, load, pay_card, nickel, dime, quarter, dollar, cancel;
    logic [71:0] cost_in;
    logic [23:0] inv_in;
    logic [2:0]  index;
    logic [8:0]  card_balance;
    logic        dispensed, sold_out, coin_reject, change_done, exact_change;
    logic [8:0]  credit, owed;
    logic [4:0]  quart, dim, nick;
    logic [23:0] inv_out;

    vending_machine_param dut (
        .clk(clk), .rst(rst), .load(load), .cost_in(cost_in), .inv_in(inv_in),
        .index(index), .pay_card(pay_card), .card_balance(card_balance),
        .nickel(nickel), .dime(dime), .quarter(quarter), .dollar(dollar), .cancel(cancel),
        .dispensed(dispensed), .sold_out(sold_out), .coin_reject(coin_reject),
        .credit(credit), .owed(owed), .quart(quart), .dim(dim), .nick(nick),
        .change_done(change_done), .exact_change(exact_change), .inv_out(inv_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] credit;
        logic [8:0] owed;
        logic [4:0] quart;
        logic [4:0] dim;
        logic [4:0] nick;
        logic [4:0] fl;     // {reject, dispensed, sold_out, change_done, exact_change}
        logic [2:0] inv2;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       load;
        logic [3:0] coins;  // {dollar, quarter, dime, nickel}
        logic       cancel;
        logic [2:0] idx;
        exp_t       e;
    } vec_t;

    localparam logic [3:0] CN = 4'b0001, CD = 4'b0010, CQ = 4'b0100, CS = 4'b1000;
    localparam logic [4:0] F_REJ = 5'b10000, F_DISP = 5'b01000, F_SOLD = 5'b00100,
                           F_DONE = 5'b00010, F_EX = 5'b00001;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic r, logic ld, logic [3:0] c, logic can, logic [2:0] ix,
                                int cr, int ow, int q, int d, int n, logic [4:0] fl, int i2);
        vec_t v;
        v.rst     = r;
        v.load    = ld;
        v.coins   = c;
        v.cancel  = can;
        v.idx     = ix;
        v.e.credit = 9'(cr);
        v.e.owed   = 9'(ow);
        v.e.quart  = 5'(q);
        v.e.dim    = 5'(d);
        v.e.nick   = 5'(n);
        v.e.fl     = fl;
        v.e.inv2   = 3'(i2);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        int i;
        cyc = -1;
        i = 0;
        while (cyc < 0 && i < maxc) begin
            i++;
            step();
            if (change_done === 1'b1) cyc = i;
        end
    endtask

    task automatic clear_in();
        rst = 0; load = 0; pay_card = 0; nickel = 0; dime = 0; quarter = 0;
        dollar = 0; cancel = 0; card_balance = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t a;
        int   c, cnt, nto, ndisp, nz;

        clear_in();
        index   = 3'd2;
        cost_in = {8{9'd100}};
        inv_in  = {3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};   // slot 5 empty

        // Dollar with empty tables then cancel; restock; sold-out slot; vend with change.
        vq.push_back(mk(1, 0, 0,       0, 2, 0,   0, 0, 0, 0, 0,      0));
        vq.push_back(mk(0, 0, CS,      0, 2, 100, 0, 0, 0, 0, 0,      0));
        vq.push_back(mk(0, 0, 0,       0, 2, 100, 0, 0, 0, 0, F_SOLD, 0));
        vq.push_back(mk(0, 0, 0,       1, 2, 100, 0, 0, 0, 0, F_SOLD, 0));
        vq.push_back(mk(0, 0, 0,       0, 2, 75,  0, 1, 0, 0, 0,      0));
        vq.push_back(mk(0, 0, 0,       0, 2, 50,  0, 2, 0, 0, 0,      0));
        vq.push_back(mk(0, 0, 0,       0, 2, 25,  0, 3, 0, 0, 0,      0));
        vq.push_back(mk(0, 0, 0,       0, 2, 0,   0, 4, 0, 0, 0,      0));
        vq.push_back(mk(0, 0, 0,       0, 2, 0,   0, 4, 0, 0, F_DONE, 0));
        vq.push_back(mk(0, 0, 0,       0, 2, 0,   0, 4, 0, 0, 0,      0));
        vq.push_back(mk(0, 1, 0,       0, 2, 0,   0, 4, 0, 0, 0,      4));
        vq.push_back(mk(0, 0, CS | CQ, 0, 5, 125, 0, 0, 0, 0, 0,      4));
        vq.push_back(mk(0, 0, 0,       0, 5, 125, 0, 0, 0, 0, F_SOLD, 4));
        vq.push_back(mk(0, 0, CD,      0, 5, 135, 0, 0, 0, 0, F_SOLD, 4));
        vq.push_back(mk(0, 0, 0,       0, 2, 135, 0, 0, 0, 0, 0,      4));
        vq.push_back(mk(0, 0, CN,      0, 2, 35,  0, 0, 0, 0, F_DISP, 3));
        vq.push_back(mk(0, 0, 0,       1, 2, 10,  0, 1, 0, 0, 0,      3));
        vq.push_back(mk(0, 0, 0,       0, 2, 0,   0, 1, 1, 0, 0,      3));
        vq.push_back(mk(0, 0, 0,       0, 2, 0,   0, 1, 1, 0, F_DONE, 3));
        vq.push_back(mk(0, 0, 0,       0, 2, 0,   0, 1, 1, 0, 0,      3));
        // Credit ceiling at 511 and a refund that exhausts every tube.
        vq.push_back(mk(1, 0, 0,       0, 2, 0,   0, 0, 0, 0, 0,      0));
        vq.push_back(mk(0, 0, CS,      0, 2, 100, 0, 0, 0, 0, 0,      0));
        for (int k = 2; k <= 5; k++)
            vq.push_back(mk(0, 0, CS, 0, 2, 100 * k, 0, 0, 0, 0, F_SOLD, 0));
        vq.push_back(mk(0, 0, CS,      0, 2, 500, 0, 0, 0, 0, F_REJ | F_SOLD, 0));
        vq.push_back(mk(0, 0, CN | CD, 0, 2, 500, 0, 0, 0, 0, F_REJ | F_SOLD, 0));
        vq.push_back(mk(0, 0, CN,      0, 2, 505, 0, 0, 0, 0, F_SOLD, 0));
        vq.push_back(mk(0, 0, 0,       1, 2, 505, 0, 0, 0, 0, F_SOLD, 0));
        for (int j = 1; j <= 10; j++)
            vq.push_back(mk(0, 0, 0, 0, 2, 505 - 25 * j, 0, j, 0, 0, 0, 0));
        for (int j = 1; j <= 10; j++)
            vq.push_back(mk(0, 0, 0, 0, 2, 255 - 10 * j, 0, 10, j, 0, (j == 10) ? F_EX : 5'b0, 0));
        for (int j = 1; j <= 11; j++)
            vq.push_back(mk(0, 0, 0, 0, 2, 155 - 5 * j, 0, 10, 10, j, F_EX, 0));
        vq.push_back(mk(0, 0, 0,       0, 2, 0, 100, 10, 10, 11, F_DONE | F_EX, 0));

        for (int i = 0; i < vq.size(); i++) begin
            rst     = vq[i].rst;
            load    = vq[i].load;
            {dollar, quarter, dime, nickel} = vq[i].coins;
            cancel  = vq[i].cancel;
            index   = vq[i].idx;
            step();
            a.credit = credit;
            a.owed   = owed;
            a.quart  = quart;
            a.dim    = dim;
            a.nick   = nick;
            a.fl     = {coin_reject, dispensed, sold_out, change_done, exact_change};
            a.inv2   = inv_out[8:6];
            n_vec++;
            if (a !== vq[i].e) begin
                n_fail++;
                $display("FAIL vec%0d: got cr=%0d ow=%0d q=%0d d=%0d n=%0d fl=%b inv2=%0d, expected cr=%0d ow=%0d q=%0d d=%0d n=%0d fl=%b inv2=%0d",
                         i, a.credit, a.owed, a.quart, a.dim, a.nick, a.fl, a.inv2,
                         vq[i].e.credit, vq[i].e.owed, vq[i].e.quart, vq[i].e.dim,
                         vq[i].e.nick, vq[i].e.fl, vq[i].e.inv2);
            end
        end
        clear_in();

        // Nickel+dollar pair buys a 100c item and returns one nickel; a second pair starts afresh.
        rst = 1; step(); rst = 0;
        cost_in = {8{9'd100}};
        inv_in  = {8{3'd4}};
        load = 1; step(); load = 0;
        index = 3'd2;
        nickel = 1; dollar = 1; step(); nickel = 0; dollar = 0;
        chk("A credit after pair", credit, 105);
        step();
        chk("A no dispense while deciding", dispensed, 0);
        step();
        chk("A dispensed", dispensed, 1);
        chk("A inv slot2", inv_out[8:6], 3);
        chk("A credit after vend", credit, 5);
        wait_done(10, c);
        chk("A change cycles", c, 2);
        chk("A nick", nick, 1);
        chk("A quart", quart, 0);
        chk("A dim", dim, 0);
        chk("A credit cleared", credit, 0);
        chk("A owed", owed, 0);
        chk("A dispensed once", dispensed, 0);
        nickel = 1; dollar = 1; step(); nickel = 0; dollar = 0;
        chk("A2 counts cleared", nick, 0);
        chk("A2 credit", credit, 105);
        wait_done(10, c);
        chk("A2 change cycles", c, 4);
        chk("A2 inv slot2", inv_out[8:6], 2);
        chk("A2 nick", nick, 1);

        // Card payment: balance one cent short is refused, exact balance vends.
        index = 3'd3; pay_card = 1; card_balance = 9'd99;
        ndisp = 0;
        repeat (3) begin
            step();
            ndisp += int'(dispensed);
        end
        chk("B short balance no vend", ndisp, 0);
        card_balance = 9'd100;
        step();
        chk("B not dispensed after 1 cycle", dispensed, 0);
        pay_card = 0;
        step();
        chk("B dispensed after 2 cycles", dispensed, 1);
        chk("B inv slot3", inv_out[11:9], 3);
        chk("B credit untouched", credit, 0);
        chk("B nick unchanged", nick, 1);
        chk("B quart unchanged", quart, 0);
        step();
        chk("B pulse one cycle", dispensed, 0);
        clear_in();

        // Drain dime and nickel tubes with 85c purchases, then a 90c purchase leaves 10c owed.
        rst = 1; step(); rst = 0;
        cost_in = {8{9'd85}};
        inv_in  = {8{3'd7}};
        load = 1; step(); load = 0;
        nto = 0;
        for (int k = 0; k < 10; k++) begin
            index = (k < 7) ? 3'd0 : 3'd1;
            dollar = 1; step(); dollar = 0;
            wait_done(20, c);
            if (c < 0) nto++;
            if (k == 8) chk("C exact_change still clear", exact_change, 0);
        end
        chk("C drain transactions timed out", nto, 0);
        chk("C exact_change set", exact_change, 1);
        cost_in = {8{9'd90}};
        load = 1; step(); load = 0;
        index = 3'd0;
        dollar = 1; step(); dollar = 0;
        wait_done(20, c);
        chk("C change cycles", c, 3);
        chk("C owed", owed, 10);
        chk("C quart", quart, 0);
        chk("C dim", dim, 0);
        chk("C nick", nick, 0);
        chk("C credit", credit, 0);
        chk("C exact_change", exact_change, 1);

        // Idle timeout refunds a lone quarter; then reset lands in the middle of a refund.
        quarter = 1; step(); quarter = 0;
        cnt = -1;
        for (int i = 1; i <= 40 && cnt < 0; i++) begin
            step();
            if (quart === 5'd1) cnt = i;
        end
        chk("D timeout refund cycle", cnt, 17);
        wait_done(5, c);
        chk("D timeout done", c, 1);
        chk("D timeout owed", owed, 0);
        quarter = 1; dime = 1; step(); quarter = 0; dime = 0;
        cancel = 1; step(); cancel = 0;
        step();
        chk("D mid-change quart", quart, 1);
        chk("D mid-change credit", credit, 10);
        rst = 1; step(); rst = 0;
        chk("D rst credit", credit, 0);
        chk("D rst counts", {quart, dim, nick}, 0);
        chk("D rst owed", owed, 0);
        chk("D rst tubes refilled", exact_change, 0);
        chk("D rst inventory", inv_out, 0);
        nz = 0;
        repeat (5) begin
            step();
            nz += int'(quart != 0) + int'(dim != 0) + int'(nick != 0)
                + int'(change_done) + int'(credit != 0);
        end
        chk("D no change after rst", nz, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/vending_machine_param.md
VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 SHALL have parameter N_PROD, default 8, number of product slots.
REQ-002 SHALL have parameter PRICE_W, default 9, width of price/credit in cents.
REQ-003 SHALL have parameter INV_W, default 3, per-slot inventory width.
REQ-004 SHALL have parameter TUBE_W, default 5, coin tube/count width; TUBE_INIT, default 10, coins per tube at reset.
REQ-005 SHALL have parameter TIMEOUT, default 16, idle cycles in COLLECT before auto-refund.
REQ-006 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 load  in  1  latch cost_in/inv_in (IDLE only).
REQ-010 cost_in  in  N_PROD*PRICE_W  packed prices, slot 0 in LSBs; inv_in  in  N_PROD*INV_W  packed stock.
REQ-011 index  in  clog2(N_PROD)  selected slot; pay_card  in  1  card mode; card_balance  in  PRICE_W  card funds.
REQ-012 nickel, dime, quarter, dollar  in  1 each  coin strobes (5/10/25/100 cents), one cycle per coin.
REQ-013 cancel  in  1  request refund.
REQ-014 dispensed  out  1  one-cycle vend pulse; sold_out  out  1  selected slot empty; coin_reject  out  1  coin refused.
REQ-015 credit  out  PRICE_W  current credit; owed  out  PRICE_W  unpayable change residue of last transaction.
REQ-016 quart, dim, nick  out  TUBE_W each  coins returned in current/last transaction; change_done  out  1  one-cycle pulse.
REQ-017 exact_change  out  1  high when nickel tube is 0 or dime tube is 0.
REQ-018 inv_out  out  N_PROD*INV_W  live inventory.

Function
REQ-019 SHALL implement states IDLE, COLLECT, VEND, CHANGE; all outputs registered.
REQ-020 load in IDLE SHALL update price and inventory tables next cycle; load in other states ignored.
REQ-021 Coin strobes in IDLE/COLLECT SHALL be summed the same cycle (multiple strobes allowed) and added to credit next cycle.
REQ-022 If credit + coin sum > 2^PRICE_W-1, the whole cycle's coins SHALL be refused: coin_reject pulses, credit and tubes unchanged.
REQ-023 Accepted nickel/dime/quarter SHALL increment their tube, saturating at 2^TUBE_W-1 (excess to cashbox); dollars go to cashbox.
REQ-024 IDLE->COLLECT on any accepted coin; quart/dim/nick cleared on that transition.
REQ-025 IDLE with pay_card=1: if card_balance >= price[index] and inv[index]!=0 -> VEND, no credit or change involved.
REQ-026 COLLECT: credit >= price[index] and inv[index]!=0 -> VEND; inv[index]==0 -> sold_out=1, stay.
REQ-027 COLLECT: cancel, or TIMEOUT consecutive cycles with no coin strobe -> CHANGE with full credit as refund; timeout counter resets on each coin.
REQ-028 VEND lasts one cycle: dispensed=1, inv[index] -= 1, credit -= price (coin mode); next state CHANGE if credit remains, else IDLE.
REQ-029 CHANGE SHALL return one coin per cycle, greedy: quarter if credit>=25 and tube>0, else dime if credit>=10 and tube>0, else nickel if credit>=5 and tube>0; that tube decrements, count increments, credit reduces.
REQ-030 When no coin can be returned, CHANGE SHALL load owed=credit, clear credit, pulse change_done, go IDLE.
REQ-031 cancel and coin strobes in VEND/CHANGE SHALL be ignored (coins not credited, no coin_reject).
REQ-032 index and pay_card SHALL be sampled each cycle; changing index in COLLECT re-evaluates REQ-026 against new slot.

Reset
REQ-033 rst SHALL, at any state: state=IDLE, credit=0, owed=0, all flags/pulses 0, quart/dim/nick=0, prices and inventory 0, each tube=TUBE_INIT, timeout counter 0.
REQ-034 rst mid-transaction SHALL discard credit without issuing change.

Verification
REQ-035 Load all prices 100, stock 4; slot 2; nickel+dollar together x4 -> VEND after first pair, dispensed once, quart=0 dim=0 nick=1, inv[2]=3, then further coins start new transaction.
REQ-036 pay_card=1, balance 200, slot 3 price 100 -> dispensed in 2 cycles, inv[3] decrements, quart/dim/nick unchanged.
REQ-037 Dollar inserted, cancel -> CHANGE returns quart=4, then change_done, credit=0, owed=0.
REQ-038 Nickel tube and dime tube preloaded empty (drain by refunds), price 90, insert dollar -> owed=10, exact_change=1.
REQ-039 Slot stock 0, credit >= price -> sold_out=1, no dispense; cancel refunds full credit.
REQ-040 Coin inserted then TIMEOUT idle cycles -> auto refund; rst asserted during CHANGE -> IDLE, tubes=TUBE_INIT, no further coins.
